// File: rtl/uart_disp_pkg.sv
// uart_disp_pkg: shared display types and constants for the UART hex history display.
// Also provides the hex-to-7-segment helper used by the downstream decoder bank.
package uart_disp_pkg;
   typedef logic [7:0] byte_t;
   typedef logic [3:0] nibble_t;
   localparam logic [6:0] SEG_BLANK = 7'b111_1111;
   localparam int CNT_W = 16;

   // Active-low segments {g,f,e,d,c,b,a} as wired on the DE0-CV
   function automatic logic [6:0] hex_to_seg(input nibble_t n, input logic en);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'b100_0000;
         4'h1: s = 7'b111_1001;
         4'h2: s = 7'b010_0100;
         4'h3: s = 7'b011_0000;
         4'h4: s = 7'b001_1001;
         4'h5: s = 7'b001_0010;
         4'h6: s = 7'b000_0010;
         4'h7: s = 7'b111_1000;
         4'h8: s = 7'b000_0000;
         4'h9: s = 7'b001_0000;
         4'hA: s = 7'b000_1000;
         4'hB: s = 7'b000_0011;
         4'hC: s = 7'b100_0110;
         4'hD: s = 7'b010_0001;
         4'hE: s = 7'b000_0110;
         default: s = 7'b000_1110;
      endcase
      return en ? s : SEG_BLANK;
   endfunction
endpackage

// File: rtl/act_stretch.sv
// act_stretch: holds out high for STRETCH_CYCLES clocks after the last trig.
// A trig while running reloads the full period.
module act_stretch #(
   parameter int STRETCH_CYCLES = 5_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic trig,
   output logic out
);
   localparam int W = $clog2(STRETCH_CYCLES + 1);
   logic [W-1:0] cnt, cnt_nxt;

   assign cnt_nxt = trig ? W'(STRETCH_CYCLES) : cnt - W'(cnt != '0);

   // out tracks the new counter value so it rises on the same edge that loads it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         out <= 1'b0;
      end else begin
         cnt <= cnt_nxt;
         out <= cnt_nxt != '0;
      end
   end
endmodule

// File: rtl/uart_hex_history.sv
// uart_hex_history: keeps the last NUM_BYTES received UART bytes as hex digits plus status LEDs/counters.
// Optional HEX_HISTORY_BLANK_EN: blank digits of never-written slots via digit_en.
module uart_hex_history
   import uart_disp_pkg::*;
#(
   parameter int NUM_BYTES      = 3,
   parameter int STRETCH_CYCLES = 5_000_000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   rx_valid,
   input  logic [7:0]             rx_data,
   input  logic                   rx_err,
   input  logic                   freeze,
   input  logic                   clear,
   output logic [8*NUM_BYTES-1:0] nibbles,
   output logic [2*NUM_BYTES-1:0] digit_en,
   output logic                   act_led,
   output logic                   err_led,
   output logic [CNT_W-1:0]       byte_cnt,
   output logic [7:0]             drop_cnt
);
   byte_t [NUM_BYTES-1:0] hist, shifted;
   logic accept, drop;

   assign accept = rx_valid & ~rx_err & ~freeze & ~clear;
   assign drop   = rx_valid & ~rx_err & freeze & ~clear;

   for (genvar i = 0; i < NUM_BYTES; i++) begin : g_shift
      if (i == 0) begin : g_head
         assign shifted[i] = rx_data;
      end else begin : g_tail
         assign shifted[i] = hist[i-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) hist <= '0;
      else     hist <= clear ? '0 : accept ? shifted : hist;
   end

   assign nibbles = hist;

`ifdef HEX_HISTORY_BLANK_EN
   logic [NUM_BYTES-1:0] fill;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) fill <= '0;
      else     fill <= clear ? '0 : accept ? NUM_BYTES'({fill, 1'b1}) : fill;
   end

   for (genvar i = 0; i < NUM_BYTES; i++) begin : g_en
      assign digit_en[2*i +: 2] = {2{fill[i]}};
   end
`else
   assign digit_en = '1;
`endif

   // clear outranks error, accept and drop events arriving in the same cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_led  <= 1'b0;
         byte_cnt <= '0;
         drop_cnt <= '0;
      end else if (clear) begin
         err_led  <= 1'b0;
         byte_cnt <= '0;
         drop_cnt <= '0;
      end else begin
         err_led  <= err_led | (rx_valid & rx_err);
         byte_cnt <= byte_cnt + CNT_W'(accept);
         drop_cnt <= drop_cnt + 8'(drop && drop_cnt != 8'hFF);
      end
   end

   act_stretch #(.STRETCH_CYCLES(STRETCH_CYCLES)) u_act (
      .clk (clk),
      .rst (rst),
      .trig(accept),
      .out (act_led)
   );
endmodule

// File: tb/tb_uart_hex_history.sv
// tb_uart_hex_history: table vectors, corner sequences and random traffic vs. a queue-based model.
module tb_uart_hex_history;
   localparam int NB = 3;
   localparam int S  = 10;

   logic clk = 1'b0, rst = 1'b1;
   logic rx_valid = 1'b0, rx_err = 1'b0, freeze = 1'b0, clear = 1'b0;
   logic [7:0] rx_data = '0;
   logic [8*NB-1:0] nibbles;
   logic [2*NB-1:0] digit_en;
   logic act_led, err_led;
   logic [15:0] byte_cnt;
   logic [7:0] drop_cnt;

   int n_checks = 0, n_fail = 0;

   // reference model state
   logic [7:0] m_hist[NB];
   int m_fill, m_bc, m_dc, m_edge, m_last;
   bit m_err, m_seen;

   uart_hex_history #(.NUM_BYTES(NB), .STRETCH_CYCLES(S)) dut (
      .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_err(rx_err),
      .freeze(freeze), .clear(clear), .nibbles(nibbles), .digit_en(digit_en),
      .act_led(act_led), .err_led(err_led), .byte_cnt(byte_cnt), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   function automatic logic [8*NB-1:0] exp_nib();
      logic [8*NB-1:0] r;
      for (int i = 0; i < NB; i++) r[8*i +: 8] = m_hist[i];
      return r;
   endfunction

   function automatic logic [2*NB-1:0] exp_en();
      logic [2*NB-1:0] r;
`ifdef HEX_HISTORY_BLANK_EN
      for (int i = 0; i < NB; i++) r[2*i +: 2] = {2{i < m_fill}};
`else
      r = '1;
`endif
      return r;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NB; i++) m_hist[i] = 8'h00;
      m_fill = 0; m_bc = 0; m_dc = 0; m_err = 0; m_seen = 0;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".nibbles"}, 32'(nibbles), 32'(exp_nib()));
      chk({tag, ".digit_en"}, 32'(digit_en), 32'(exp_en()));
      chk({tag, ".byte_cnt"}, 32'(byte_cnt), 32'(m_bc));
      chk({tag, ".drop_cnt"}, 32'(drop_cnt), 32'(m_dc));
      chk({tag, ".err_led"}, 32'(err_led), 32'(m_err));
      chk({tag, ".act_led"}, 32'(act_led), 32'(m_seen && (m_edge - m_last) < S));
   endtask

   task automatic step(input logic v, input logic [7:0] d, input logic e, input logic f,
                       input logic c, input string tag);
      bit acc;
      rx_valid = v; rx_data = d; rx_err = e; freeze = f; clear = c;
      @(posedge clk);
      #1;
      acc = v && !e && !f && !c;
      m_edge++;
      if (acc) begin m_last = m_edge; m_seen = 1; end
      if (c) begin
         for (int i = 0; i < NB; i++) m_hist[i] = 8'h00;
         m_fill = 0; m_bc = 0; m_dc = 0; m_err = 0;
      end else begin
         if (v && e) m_err = 1;
         if (acc) begin
            for (int i = NB - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = d;
            if (m_fill < NB) m_fill++;
            m_bc = (m_bc + 1) % 65536;
         end
         if (v && !e && f && m_dc < 255) m_dc++;
      end
      rx_valid = 0; rx_err = 0; clear = 0;
      check_all(tag);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      check_all("reset");
   endtask

   typedef struct {
      logic v; logic [7:0] d; logic e; logic c;
      logic [23:0] nib; logic [15:0] bc; logic err;
   } vec_t;

   vec_t tbl[10];

   initial begin
      tbl[0] = '{1, 8'hA5, 0, 0, 24'h0000A5, 16'd1, 0};
      tbl[1] = '{1, 8'h12, 0, 0, 24'h00A512, 16'd2, 0};
      tbl[2] = '{1, 8'h34, 0, 0, 24'hA51234, 16'd3, 0};
      tbl[3] = '{1, 8'h56, 0, 0, 24'h123456, 16'd4, 0};
      tbl[4] = '{1, 8'h78, 0, 0, 24'h345678, 16'd5, 0};
      tbl[5] = '{1, 8'hFF, 1, 0, 24'h345678, 16'd5, 1};
      tbl[6] = '{0, 8'h00, 0, 0, 24'h345678, 16'd5, 1};
      tbl[7] = '{0, 8'h00, 0, 1, 24'h000000, 16'd0, 0};
      tbl[8] = '{1, 8'h5A, 0, 0, 24'h00005A, 16'd1, 0};
      tbl[9] = '{1, 8'h11, 0, 1, 24'h000000, 16'd0, 0};

      m_edge = 0; m_last = 0;
      model_reset();
      #2;
      do_reset();

      for (int k = 0; k < 10; k++) begin
         step(tbl[k].v, tbl[k].d, tbl[k].e, 1'b0, tbl[k].c, $sformatf("tbl%0d", k));
         chk($sformatf("tbl%0d.nib_const", k), 32'(nibbles), 32'(tbl[k].nib));
         chk($sformatf("tbl%0d.bc_const", k), 32'(byte_cnt), 32'(tbl[k].bc));
         chk($sformatf("tbl%0d.err_const", k), 32'(err_led), 32'(tbl[k].err));
      end
`ifdef HEX_HISTORY_BLANK_EN
      chk("clear_blank.digit_en", 32'(digit_en), 32'h0);
`else
      chk("clear_blank.digit_en", 32'(digit_en), 32'h3F);
`endif

      // freeze: 300 good bytes dropped, counter saturates, then capture resumes
      step(1, 8'h21, 0, 0, 0, "pre_freeze");
      for (int k = 0; k < 300; k++) step(1, 8'($urandom), 0, 1, 0, "frozen");
      chk("freeze.drop_sat", 32'(drop_cnt), 32'hFF);
      chk("freeze.hist_hold", 32'(nibbles), 32'h000021);
      step(1, 8'h9C, 0, 0, 0, "unfreeze");
      chk("unfreeze.slot0", 32'(nibbles[7:0]), 32'h9C);
      step(1, 8'hEE, 1, 1, 0, "err_frozen");
      chk("err_frozen.err", 32'(err_led), 32'h1);

      // stretch retrigger: strobe, retrigger 5 edges later, LED falls S edges after retrigger
      do_reset();
      step(1, 8'h01, 0, 0, 0, "st0");
      for (int k = 0; k < 4; k++) step(0, 8'h00, 0, 0, 0, "st_gap");
      step(1, 8'h02, 0, 0, 0, "st_retrig");
      for (int k = 1; k <= 12; k++) begin
         step(0, 8'h00, 0, 0, 0, "st_run");
         chk($sformatf("stretch.k%0d", k), 32'(act_led), 32'(k < S));
      end

      // clear leaves act_led alone; async reset kills it mid-count without a clock edge
      step(1, 8'h03, 0, 0, 0, "st_again");
      step(0, 8'h00, 0, 0, 1, "clear_act");
      chk("clear_keeps_act", 32'(act_led), 32'h1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst.act", 32'(act_led), 32'h0);
      chk("async_rst.nib", 32'(nibbles), 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      model_reset();

      // random traffic against the model
      for (int k = 0; k < 600; k++)
         step($urandom_range(0, 1), 8'($urandom), $urandom_range(0, 7) == 0,
              $urandom_range(0, 5) == 0, $urandom_range(0, 30) == 0, "rand");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
